// File: rtl/sram_cache_controller_if.sv
// Bus bundle for sram_cache_controller: MEM-stage request/response signals
// plus the SRAM-controller request/response signals. The cache uses the
// slave view; the surrounding pipeline/SRAM environment uses the master view.
interface sram_cache_controller_if;
  // MEM-stage side
  logic        read_en;
  logic        write_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  // SRAM-controller side
  logic        sram_read_en;
  logic        sram_write_en;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;
  logic        sram_ready;

  modport master (
    output read_en, write_en, address, write_data, sram_read_data, sram_ready,
    input  read_data, ready, sram_read_en, sram_write_en, sram_address, sram_write_data
  );

  modport slave (
    input  read_en, write_en, address, write_data, sram_read_data, sram_ready,
    output read_data, ready, sram_read_en, sram_write_en, sram_address, sram_write_data
  );
endinterface

// File: rtl/sram_cache_controller.sv
// Two-way set-associative read cache between the MEM stage and the SRAM
// controller. Read hits complete in the same cycle; read misses fill a 64-bit
// line with two sequential 32-bit SRAM reads; writes go straight through to
// SRAM without allocation and invalidate a matching cached line.
module sram_cache_controller #(
  parameter int unsigned BASE_ADDR  = 1024,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  sram_cache_controller_if.slave  bus
);

  localparam int unsigned SETS = 1 << INDEX_BITS;
  // Word offset width: word select + index + tag.
  localparam int unsigned OW   = TAG_BITS + INDEX_BITS + 1;
  localparam logic [31:0] BASE = 32'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, FILL0, FILL1, WRITE} state_t;

  state_t                state_q;
  logic                  sram_read_en_q;
  logic                  sram_write_en_q;
  logic [31:0]           word0_q;
  logic [SETS-1:0]       valid0_q;
  logic [SETS-1:0]       valid1_q;
  logic [SETS-1:0]       lru_q;
  logic [TAG_BITS-1:0]   tag0_q  [SETS];
  logic [TAG_BITS-1:0]   tag1_q  [SETS];
  logic [63:0]           data0_q [SETS];
  logic [63:0]           data1_q [SETS];

  logic [OW-1:0]         woff;
  logic                  word_sel;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [31:0]           line_base;
  logic                  hit0;
  logic                  hit1;
  logic                  hit;
  logic [63:0]           hit_line;
  logic                  victim;
  logic                  ready_d;
  logic [31:0]           read_data_d;
  logic [31:0]           sram_address_d;
  logic [31:0]           sram_write_data_d;

  // Address decode works on word offsets; the byte bits are always zero.
  assign woff      = bus.address[OW+1:2] - BASE[OW+1:2];
  assign word_sel  = woff[0];
  assign index     = woff[INDEX_BITS:1];
  assign tag       = woff[OW-1:INDEX_BITS+1];
  assign line_base = {bus.address[31:3], 3'b000};

  assign hit0     = valid0_q[index] && (tag0_q[index] == tag);
  assign hit1     = valid1_q[index] && (tag1_q[index] == tag);
  assign hit      = hit0 || hit1;
  assign hit_line = hit0 ? data0_q[index] : data1_q[index];

  // Victim: first invalid way (way0 first), otherwise the LRU pointer.
  assign victim = !valid0_q[index] ? 1'b0 :
                  !valid1_q[index] ? 1'b1 : lru_q[index];

  // Control FSM with registered SRAM request enables and per-set valid/LRU state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      sram_read_en_q  <= 1'b0;
      sram_write_en_q <= 1'b0;
      word0_q         <= '0;
      valid0_q        <= '0;
      valid1_q        <= '0;
      lru_q           <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.write_en) begin
            if (hit0) valid0_q[index] <= 1'b0;
            if (hit1) valid1_q[index] <= 1'b0;
            sram_write_en_q <= 1'b1;
            state_q         <= WRITE;
          end else if (bus.read_en) begin
            if (hit) begin
              lru_q[index] <= hit0;
            end else begin
              sram_read_en_q <= 1'b1;
              state_q        <= FILL0;
            end
          end
        end
        FILL0: begin
          if (bus.sram_ready) begin
            word0_q <= bus.sram_read_data;
            state_q <= FILL1;
          end
        end
        FILL1: begin
          if (bus.sram_ready) begin
            if (victim) valid1_q[index] <= 1'b1;
            else        valid0_q[index] <= 1'b1;
            lru_q[index]   <= ~victim;
            sram_read_en_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        WRITE: begin
          if (bus.sram_ready) begin
            sram_write_en_q <= 1'b0;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage: tag and data of the victim way written when the fill completes.
  always_ff @(posedge clk) begin
    if (state_q == FILL1 && bus.sram_ready) begin
      if (victim) begin
        tag1_q[index]  <= tag;
        data1_q[index] <= {bus.sram_read_data, word0_q};
      end else begin
        tag0_q[index]  <= tag;
        data0_q[index] <= {bus.sram_read_data, word0_q};
      end
    end
  end

  // Pipeline handshake, load data and SRAM address/data for the current state.
  always_comb begin
    ready_d           = 1'b1;
    read_data_d       = '0;
    sram_address_d    = '0;
    sram_write_data_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.write_en) begin
          ready_d = 1'b0;
        end else if (bus.read_en) begin
          ready_d = hit;
          if (hit) read_data_d = word_sel ? hit_line[63:32] : hit_line[31:0];
        end
      end
      FILL0: begin
        ready_d        = 1'b0;
        sram_address_d = line_base;
      end
      FILL1: begin
        ready_d        = bus.sram_ready;
        sram_address_d = {bus.address[31:3], 3'b100};
        if (bus.sram_ready) read_data_d = word_sel ? bus.sram_read_data : word0_q;
      end
      WRITE: begin
        ready_d           = bus.sram_ready;
        sram_address_d    = bus.address;
        sram_write_data_d = bus.write_data;
      end
      default: ready_d = 1'b1;
    endcase
  end

  assign bus.ready           = ready_d;
  assign bus.read_data       = read_data_d;
  assign bus.sram_read_en    = sram_read_en_q;
  assign bus.sram_write_en   = sram_write_en_q;
  assign bus.sram_address    = sram_address_d;
  assign bus.sram_write_data = sram_write_data_d;

endmodule

// File: tb/tb_sram_cache_controller.sv
// Directed testbench for sram_cache_controller with a small SRAM-controller
// model (5 wait cycles, idle-high ready, one-cycle completion pulse).
module tb_sram_cache_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  sram_cache_controller_if bus ();

  sram_cache_controller #(
    .BASE_ADDR (1024),
    .INDEX_BITS(6),
    .TAG_BITS  (10)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- SRAM controller model ----------------
  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mstate_t;

  bit          mem_init = 1'b0;
  logic [31:0] mem [4096];
  mstate_t     mst      = M_IDLE;
  int unsigned mcnt     = 0;
  logic        m_wr     = 1'b0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wd     = '0;
  logic [31:0] m_rdata  = '0;
  int          rd_count = 0;
  int          wr_count = 0;
  logic [31:0] rd_last  = '0;
  logic [31:0] rd_prev  = '0;
  logic [31:0] wr_last  = '0;

  // Memory preload once, then serve one request per enable with fixed latency.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int unsigned i = 0; i < 4096; i++) mem[12'(i)] <= '0;
      mem[12'h100] <= 32'h11;   // 0x400
      mem[12'h101] <= 32'h22;   // 0x404
      mem[12'h180] <= 32'h33;   // 0x600
      mem[12'h181] <= 32'h44;   // 0x604
      mem[12'h200] <= 32'h55;   // 0x800
      mem[12'h201] <= 32'h66;   // 0x804
      mem_init     <= 1'b1;
    end
    if (!rst_n) begin
      mst  <= M_IDLE;
      mcnt <= 0;
    end else begin
      case (mst)
        M_IDLE: if (bus.sram_read_en || bus.sram_write_en) begin
          m_addr <= bus.sram_address;
          m_wr   <= bus.sram_write_en;
          m_wd   <= bus.sram_write_data;
          mcnt   <= 5;
          mst    <= M_BUSY;
        end
        M_BUSY: if (mcnt == 0) begin
          mst <= M_DONE;
          if (m_wr) begin
            mem[m_addr[13:2]] <= m_wd;
            wr_count          <= wr_count + 1;
            wr_last           <= m_addr;
          end else begin
            m_rdata  <= mem[m_addr[13:2]];
            rd_count <= rd_count + 1;
            rd_prev  <= rd_last;
            rd_last  <= m_addr;
          end
        end else begin
          mcnt <= mcnt - 1;
        end
        default: mst <= M_IDLE;
      endcase
    end
  end

  assign bus.sram_ready     = (mst == M_DONE) ||
                              (mst == M_IDLE && !bus.sram_read_en && !bus.sram_write_en);
  assign bus.sram_read_data = m_rdata;

  // ---------------- checking helpers ----------------
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One pipeline access held until ready; returns load data, stall cycles
  // and whether sram_read_en was seen during the access.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output int cycles, output logic saw_rd);
    @(negedge clk);
    bus.read_en    = rd;
    bus.write_en   = wr;
    bus.address    = a;
    bus.write_data = d;
    cycles = 0;
    saw_rd = 1'b0;
    #1;
    while (bus.ready !== 1'b1 && cycles < 200) begin
      saw_rd |= bus.sram_read_en;
      @(negedge clk);
      #1;
      cycles++;
    end
    saw_rd |= bus.sram_read_en;
    rdata = bus.read_data;
    check1({tag, " no timeout"}, cycles < 200, 1'b1);
    @(posedge clk);
    #1;
    bus.read_en  = 1'b0;
    bus.write_en = 1'b0;
  endtask

  task automatic rd_test(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_data, input logic exp_hit);
    logic [31:0] rdata;
    int          cycles;
    logic        saw_rd;
    int          rb = rd_count;
    int          wb = wr_count;
    access(tag, 1'b1, 1'b0, a, 32'h0, rdata, cycles, saw_rd);
    check32({tag, " data"}, rdata, exp_data);
    check1({tag, " hit"}, cycles == 0, exp_hit);
    check32({tag, " sram reads"}, 32'(rd_count - rb), exp_hit ? 32'd0 : 32'd2);
    check32({tag, " sram writes"}, 32'(wr_count - wb), 32'd0);
    if (exp_hit) begin
      check1({tag, " no sram_read_en"}, saw_rd, 1'b0);
    end else begin
      check32({tag, " fill addr0"}, rd_prev, {a[31:3], 3'b000});
      check32({tag, " fill addr1"}, rd_last, {a[31:3], 3'b100});
    end
  endtask

  task automatic wr_test(input string tag, input logic also_rd,
                         input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rdata;
    int          cycles;
    logic        saw_rd;
    int          rb = rd_count;
    int          wb = wr_count;
    access(tag, also_rd, 1'b1, a, d, rdata, cycles, saw_rd);
    check1({tag, " stalled"}, cycles > 0, 1'b1);
    check32({tag, " sram writes"}, 32'(wr_count - wb), 32'd1);
    check32({tag, " sram reads"}, 32'(rd_count - rb), 32'd0);
    check1({tag, " no sram_read_en"}, saw_rd, 1'b0);
    check32({tag, " write addr"}, wr_last, a);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int base;

    bus.read_en    = 1'b0;
    bus.write_en   = 1'b0;
    bus.address    = 32'h400;
    bus.write_data = '0;

    repeat (3) @(negedge clk);
    #1;
    check1("reset ready", bus.ready, 1'b1);
    check32("reset read_data", bus.read_data, 32'h0);
    check1("reset sram_read_en", bus.sram_read_en, 1'b0);
    check1("reset sram_write_en", bus.sram_write_en, 1'b0);
    rst_n = 1'b1;

    // Cold miss then hit in the same line.
    rd_test("cold miss 0x404", 32'h404, 32'h22, 1'b0);
    rd_test("hit 0x400", 32'h400, 32'h11, 1'b1);

    // LRU replacement in set 0.
    rd_test("miss 0x600", 32'h600, 32'h33, 1'b0);
    rd_test("hit 0x400 lru", 32'h400, 32'h11, 1'b1);
    rd_test("miss 0x800 evicts 0x600", 32'h800, 32'h55, 1'b0);
    rd_test("hit 0x400 kept", 32'h400, 32'h11, 1'b1);
    rd_test("miss 0x600 evicted", 32'h600, 32'h33, 1'b0);

    // Write hit invalidates the line.
    wr_test("write hit 0x400", 1'b0, 32'h400, 32'hDEADBEEF);
    rd_test("miss after invalidate", 32'h400, 32'hDEADBEEF, 1'b0);

    // Write miss does not allocate.
    wr_test("write miss 0x1000", 1'b0, 32'h1000, 32'h5);
    rd_test("miss 0x1000", 32'h1000, 32'h5, 1'b0);
    rd_test("hit 0x400 after no-alloc", 32'h400, 32'hDEADBEEF, 1'b1);

    // Write has priority over a simultaneous read.
    wr_test("rd+wr 0x408", 1'b1, 32'h408, 32'h77);
    rd_test("miss 0x40c word1", 32'h40C, 32'h0, 1'b0);
    rd_test("hit 0x408 written", 32'h408, 32'h77, 1'b1);

    // Reset in the middle of a fill.
    @(negedge clk);
    bus.read_en = 1'b1;
    bus.address = 32'h600;
    base = rd_count;
    n = 0;
    while (rd_count == base && n < 200) begin
      @(negedge clk);
      n++;
    end
    check1("fill0 no timeout", n < 200, 1'b1);
    @(negedge clk);
    #1;
    check1("fill1 sram_read_en", bus.sram_read_en, 1'b1);
    check32("fill1 sram_address", bus.sram_address, 32'h604);
    check1("fill1 ready low", bus.ready, 1'b0);
    rst_n       = 1'b0;
    bus.read_en = 1'b0;
    #1;
    check1("mid-fill reset sram_read_en", bus.sram_read_en, 1'b0);
    check1("mid-fill reset sram_write_en", bus.sram_write_en, 1'b0);
    check1("mid-fill reset ready", bus.ready, 1'b1);
    check32("mid-fill reset read_data", bus.read_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_test("miss 0x400 after reset", 32'h400, 32'hDEADBEEF, 1'b0);
    rd_test("miss 0x600 after reset", 32'h600, 32'h33, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
